// File: rtl/onehot_idx_encoder_pkg.sv
// +--------------------------------------------------------------------------+
// | onehot_pkg : shared widths and the one-hot -> {err, idx} reference encode |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package onehot_pkg;

    localparam int DEF_IDX_W     = 3;
    localparam int DEF_N         = 2 ** DEF_IDX_W;
    localparam bit DEF_MSB_FIRST = 1'b1;

    typedef struct packed {
        logic                 err;
        logic [DEF_IDX_W-1:0] idx;
    } enc_t;

    // Multi-hot resolves to the lowest index; zero-hot gives index 0. Both flag err.
    function automatic enc_t onehot_to_idx(input logic [DEF_N-1:0] code);
        enc_t res;
        res.idx = '0;
        for (int i = DEF_N - 1; i >= 0; i--) begin
            if (code[DEF_MSB_FIRST ? (DEF_N - 1 - i) : i]) begin
                res.idx = i[DEF_IDX_W-1:0];
            end
        end
        res.err = (code == '0) || ((code & (code - {{(DEF_N-1){1'b0}}, 1'b1})) != '0);
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_idx_encoder_if.sv
// +--------------------------------------------------------------------------+
// | onehot_idx_encoder_if : valid/ready code-in and index-out handshake bus   |
// | Revision              : 1.0                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

interface onehot_idx_encoder_if
    import onehot_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W
);
    localparam int N = 2 ** IDX_W;

    logic             in_vld;
    logic             in_rdy;
    logic [N-1:0]     in_code;
    logic             out_vld;
    logic             out_rdy;
    logic [IDX_W-1:0] out_idx;
    logic             out_err;

    modport master (
        output in_vld, in_code, out_rdy,
        input  in_rdy, out_vld, out_idx, out_err
    );

    modport slave (
        input  in_vld, in_code, out_rdy,
        output in_rdy, out_vld, out_idx, out_err
    );

endinterface

`default_nettype wire

// File: rtl/onehot_idx_encoder_skid.sv
// +--------------------------------------------------------------------------+
// | idx_skid_buf : 2-entry valid/ready skid buffer, registered in_rdy         |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module idx_skid_buf #(
    parameter int WIDTH = 4
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              in_vld,
    output logic             in_rdy,
    input  wire  [WIDTH-1:0] in_data,
    output logic             out_vld,
    input  wire              out_rdy,
    output logic [WIDTH-1:0] out_data
);

    logic             main_vld;
    logic             skid_vld;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             load_main;

    assign accept    = in_vld && !skid_vld;
    assign load_main = !main_vld || out_rdy;

    // Skid is only ever full while main is full, so in_rdy low blocks any accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld  <= 1'b0;
            skid_vld  <= 1'b0;
            main_data <= '0;
            skid_data <= '0;
        end else if (load_main) begin
            if (skid_vld) begin
                main_data <= skid_data;
                main_vld  <= 1'b1;
                skid_vld  <= 1'b0;
            end else begin
                main_vld <= accept;
                if (accept) begin
                    main_data <= in_data;
                end
            end
        end else if (accept) begin
            skid_data <= in_data;
            skid_vld  <= 1'b1;
        end
    end

    assign in_rdy   = !skid_vld;
    assign out_vld  = main_vld;
    assign out_data = main_data;

endmodule

`default_nettype wire

// File: rtl/onehot_idx_encoder.sv
// +--------------------------------------------------------------------------+
// | onehot_idx_encoder : one-hot select word -> registered {err, idx}         |
// | Optional saturating error counter: ONEHOT_ERR_CNT_EN  Revision : 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module onehot_idx_encoder
    import onehot_pkg::*;
#(
    parameter int IDX_W     = DEF_IDX_W,
    parameter bit MSB_FIRST = DEF_MSB_FIRST,
    parameter int CNT_W     = 16
) (
    input  wire              clk,
    input  wire              rst,
    onehot_idx_encoder_if.slave bus,
    input  wire              err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int N = 2 ** IDX_W;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_err;
    logic [IDX_W:0]   out_word;
    logic             accept;

    // Walking from the highest index down lets the lowest set index win.
    always_comb begin
        enc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.in_code[MSB_FIRST ? (N - 1 - i) : i]) begin
                enc_idx = i[IDX_W-1:0];
            end
        end
        enc_err = (bus.in_code == '0) ||
                  ((bus.in_code & (bus.in_code - {{(N-1){1'b0}}, 1'b1})) != '0);
    end

    idx_skid_buf #(
        .WIDTH (IDX_W + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (bus.in_vld),
        .in_rdy   (bus.in_rdy),
        .in_data  ({enc_err, enc_idx}),
        .out_vld  (bus.out_vld),
        .out_rdy  (bus.out_rdy),
        .out_data (out_word)
    );

    assign bus.out_idx = out_word[IDX_W-1:0];
    assign bus.out_err = out_word[IDX_W];
    assign accept      = bus.in_vld && bus.in_rdy;

`ifdef ONEHOT_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (accept && enc_err && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = err_clr ^ accept ^ enc_err;
    assign err_cnt           = '0;
`endif

endmodule

`default_nettype wire
